mem_port_arbiter: RTL and testbench

Shares one single-port unified memory between the Fetch stage (instruction reads) and the Memory stage (data loads/stores) of the 5-stage RV32I pipeline. It uses a registered FSM with fixed data-over-fetch priority and a request/ready memory handshake. It drives stall/freeze requests that sit alongside the hazard unit's StallF/StallD/FlushE. A watchdog counter bounds every memory transaction.

---
 rtl/mem_port_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one single-port memory between instruction fetch and data
//            access, data first, with a watchdog on every memory transaction.
// Revision : 1.0 - initial release
// ============================================================================

module mem_port_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int WAIT_LIMIT    = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     FetchReq,
  input  logic [ADDRESS_WIDTH-1:0] FetchAddr,
  input  logic                     FlushFetch,
  output logic [DATA_WIDTH-1:0]    FetchData,
  output logic                     FetchValid,
  input  logic                     DataReq,
  input  logic                     DataWe,
  input  logic [ADDRESS_WIDTH-1:0] DataAddr,
  input  logic [DATA_WIDTH-1:0]    DataWData,
  output logic [DATA_WIDTH-1:0]    DataRData,
  output logic                     DataValid,
  output logic                     MemReq,
  output logic                     MemWe,
  output logic [ADDRESS_WIDTH-1:0] MemAddr,
  output logic [DATA_WIDTH-1:0]    MemWData,
  input  logic [DATA_WIDTH-1:0]    MemRData,
  input  logic                     MemReady,
  output logic                     StallFetch,
  output logic                     FreezePipe,
  output logic                     BusError
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [7:0] c_WAIT_LIMIT = 8'(WAIT_LIMIT);

  state_t                     r_state,     w_state;
  logic [7:0]                 r_waitCnt,   w_waitCnt;
  logic                       r_kill,      w_kill;
  logic                       r_memReq,    w_memReq;
  logic                       r_memWe,     w_memWe;
  logic [ADDRESS_WIDTH-1:0]   r_memAddr,   w_memAddr;
  logic [DATA_WIDTH-1:0]      r_memWData,  w_memWData;
  logic [DATA_WIDTH-1:0]      r_fetchData, w_fetchData;
  logic [DATA_WIDTH-1:0]      r_dataRData, w_dataRData;
  logic                       r_fetchValid, w_fetchValid;
  logic                       r_dataValid,  w_dataValid;
  logic                       r_busError,   w_busError;
  logic                       w_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_waitCnt    <= '0;
      r_kill       <= 1'b0;
      r_memReq     <= 1'b0;
      r_memWe      <= 1'b0;
      r_memAddr    <= '0;
      r_memWData   <= '0;
      r_fetchData  <= '0;
      r_dataRData  <= '0;
      r_fetchValid <= 1'b0;
      r_dataValid  <= 1'b0;
      r_busError   <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_waitCnt    <= w_waitCnt;
      r_kill       <= w_kill;
      r_memReq     <= w_memReq;
      r_memWe      <= w_memWe;
      r_memAddr    <= w_memAddr;
      r_memWData   <= w_memWData;
      r_fetchData  <= w_fetchData;
      r_dataRData  <= w_dataRData;
      r_fetchValid <= w_fetchValid;
      r_dataValid  <= w_dataValid;
      r_busError   <= w_busError;
    end
  end

  // Timeout fires on the cycle the counter would reach the limit, so MemReq
  // is high for exactly WAIT_LIMIT cycles of an unanswered request.
  assign w_timeout = (r_waitCnt + 8'd1) == c_WAIT_LIMIT;

  always_comb begin
    w_state      = r_state;
    w_waitCnt    = r_waitCnt;
    w_kill       = r_kill;
    w_memReq     = r_memReq;
    w_memWe      = r_memWe;
    w_memAddr    = r_memAddr;
    w_memWData   = r_memWData;
    w_fetchData  = r_fetchData;
    w_dataRData  = r_dataRData;
    w_fetchValid = 1'b0;
    w_dataValid  = 1'b0;
    w_busError   = r_busError;

    unique case (r_state)
      IDLE: begin
        if (DataReq) begin
          w_memAddr  = DataAddr;
          w_memWe    = DataWe;
          w_memWData = DataWData;
          w_memReq   = 1'b1;
          w_waitCnt  = '0;
          w_state    = DATA;
        end else if (FetchReq) begin
          w_memAddr  = FetchAddr;
          w_memWe    = 1'b0;
          w_memReq   = 1'b1;
          w_waitCnt  = '0;
          w_kill     = 1'b0;
          w_state    = FETCH;
        end
      end

      FETCH: begin
        // A redirect at any point up to completion makes this fetch wrong-path.
        w_kill = r_kill | FlushFetch;
        if (MemReady) begin
          w_memReq     = 1'b0;
          w_fetchData  = MemRData;
          w_fetchValid = ~w_kill;
          w_state      = RESP;
        end else if (w_timeout) begin
          w_memReq     = 1'b0;
          w_busError   = 1'b1;
          w_fetchData  = '0;
          w_fetchValid = ~w_kill;
          w_waitCnt    = c_WAIT_LIMIT;
          w_state      = RESP;
        end else begin
          w_waitCnt    = r_waitCnt + 8'd1;
        end
      end

      DATA: begin
        if (MemReady) begin
          w_memReq    = 1'b0;
          w_dataValid = 1'b1;
          if (!r_memWe) w_dataRData = MemRData;
          w_state     = RESP;
        end else if (w_timeout) begin
          w_memReq    = 1'b0;
          w_busError  = 1'b1;
          w_dataRData = '0;
          w_dataValid = 1'b1;
          w_waitCnt   = c_WAIT_LIMIT;
          w_state     = RESP;
        end else begin
          w_waitCnt   = r_waitCnt + 8'd1;
        end
      end

      RESP: begin
        w_state = IDLE;
      end

      default: begin
        w_state = IDLE;
      end
    endcase
  end

  assign FetchData  = r_fetchData;
  assign FetchValid = r_fetchValid;
  assign DataRData  = r_dataRData;
  assign DataValid  = r_dataValid;
  assign MemReq     = r_memReq;
  assign MemWe      = r_memWe;
  assign MemAddr    = r_memAddr;
  assign MemWData   = r_memWData;
  assign BusError   = r_busError;

  // Redirect must never be blocked, so a flush lifts the fetch stall.
  assign StallFetch = FetchReq & ~r_fetchValid & ~FlushFetch;
  assign FreezePipe = DataReq & ~r_dataValid;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Random and directed transactions against a word-memory model;
//            completion pulses are scored from an expectation queue.
// Revision : 1.0 - initial release
// ============================================================================

module tb_mem_port_arbiter;

  localparam int WL = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        FetchReq = 1'b0;
  logic [31:0] FetchAddr = '0;
  logic        FlushFetch = 1'b0;
  logic [31:0] FetchData;
  logic        FetchValid;
  logic        DataReq = 1'b0;
  logic        DataWe = 1'b0;
  logic [31:0] DataAddr = '0;
  logic [31:0] DataWData = '0;
  logic [31:0] DataRData;
  logic        DataValid;
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic [31:0] MemRData = '0;
  logic        MemReady = 1'b0;
  logic        StallFetch;
  logic        FreezePipe;
  logic        BusError;

  mem_port_arbiter #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH   (32),
    .WAIT_LIMIT   (WL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .FetchReq  (FetchReq),
    .FetchAddr (FetchAddr),
    .FlushFetch(FlushFetch),
    .FetchData (FetchData),
    .FetchValid(FetchValid),
    .DataReq   (DataReq),
    .DataWe    (DataWe),
    .DataAddr  (DataAddr),
    .DataWData (DataWData),
    .DataRData (DataRData),
    .DataValid (DataValid),
    .MemReq    (MemReq),
    .MemWe     (MemWe),
    .MemAddr   (MemAddr),
    .MemWData  (MemWData),
    .MemRData  (MemRData),
    .MemReady  (MemReady),
    .StallFetch(StallFetch),
    .FreezePipe(FreezePipe),
    .BusError  (BusError)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        isData;
    logic [31:0] data;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] memModel[logic [31:0]];
  logic [31:0] lastRData = '0;
  bit          busErr = 1'b0;
  int          nCompared = 0;
  int          nMismatch = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (memModel.exists(a)) return memModel[a];
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  // Completion monitor: every valid pulse must match the oldest expectation.
  exp_t e;
  always @(negedge clk) begin
    if (rst_n && (FetchValid || DataValid)) begin
      if (expQ.size() == 0) begin
        check("unexpectedValid", {FetchValid, DataValid}, 2'b00);
      end else begin
        e = expQ.pop_front();
        check("validKind", {DataValid, FetchValid}, e.isData ? 2'b10 : 2'b01);
        if (e.isData) check("dataRData", DataRData, e.data);
        else          check("fetchData", FetchData, e.data);
      end
    end
  end

  // Plays the memory for one access; returns in the completion cycle.
  task automatic serveAccess(input bit isData, input bit we, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rdata,
                             input int waits, input bit tmo, input int flushAt,
                             input int expLat);
    int lat;
    int nCyc;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!MemReq && lat < 20);
    check("issueLatency", lat, expLat);
    if (!MemReq) return;
    nCyc = tmo ? WL : waits + 1;
    for (int j = 0; j < nCyc; j++) begin
      FlushFetch = (j == flushAt);
      MemReady   = !tmo && (j == waits);
      MemRData   = MemReady ? rdata : $urandom;
      #1;
      check("memReqHeld", MemReq, 1);
      check("memAddr", MemAddr, addr);
      check("memWe", MemWe, we);
      if (we) check("memWData", MemWData, wd);
      if (isData) check("freezePipe", FreezePipe, 1);
      else        check("stallFetch", StallFetch, !FlushFetch);
      @(negedge clk);
    end
    FlushFetch = 1'b0;
    MemReady   = 1'b0;
    #1;
    check("memReqDropped", MemReq, 0);
  endtask

  // mode: 0 fetch only, 1 data only, 2 both raised together.
  task automatic runTxn(input int mode, input logic [31:0] fAddr, input logic [31:0] dAddr,
                        input bit we, input logic [31:0] wd, input int dWaits,
                        input int fWaits, input bit dTmo, input bit fTmo, input int flushAt);
    bit          hasData;
    bit          hasFetch;
    bit          killed;
    logic [31:0] dResp;
    logic [31:0] fResp;
    hasData  = (mode != 0);
    hasFetch = (mode != 1);
    killed   = hasFetch && (flushAt >= 0);
    dResp    = '0;
    fResp    = '0;
    if (hasData) begin
      dResp = we ? 32'($urandom) : memRead(dAddr);
      if (dTmo) begin
        expQ.push_back('{1'b1, 32'h0});
        lastRData = '0;
        busErr    = 1'b1;
      end else if (we) begin
        expQ.push_back('{1'b1, lastRData});
        memModel[dAddr] = wd;
      end else begin
        expQ.push_back('{1'b1, dResp});
        lastRData = dResp;
      end
    end
    if (hasFetch) begin
      fResp = memRead(fAddr);
      if (fTmo) busErr = 1'b1;
      if (!killed) expQ.push_back('{1'b0, fTmo ? 32'h0 : fResp});
    end

    DataReq   = hasData;
    DataWe    = we;
    DataAddr  = dAddr;
    DataWData = wd;
    FetchReq  = hasFetch;
    FetchAddr = fAddr;
    if (hasData) begin
      serveAccess(1'b1, we, dAddr, wd, dResp, dWaits, dTmo, -1, 1);
      check("freezeAtValid", FreezePipe, 0);
      if (hasFetch) check("stallWhileData", StallFetch, 1);
      DataReq = 1'b0;
      DataWe  = 1'b0;
    end
    if (hasFetch) begin
      serveAccess(1'b0, 1'b0, fAddr, 32'h0, fResp, fWaits, fTmo, flushAt, hasData ? 2 : 1);
      check("stallAtResp", StallFetch, killed);
      FetchReq = 1'b0;
    end
    if ((hasFetch && fTmo) || (!hasFetch && dTmo)) begin
      @(negedge clk);
      @(negedge clk);
      MemReady = 1'b1;
      MemRData = $urandom;
      @(negedge clk);
      MemReady = 1'b0;
      #1;
      check("lateReadyIgnored", MemReq, 0);
    end
    @(negedge clk);
    check("busError", BusError, busErr);
  endtask

  task automatic randomTxn();
    int          mode;
    bit          we;
    int          dw;
    int          fw;
    bit          dtmo;
    bit          ftmo;
    int          fl;
    logic [31:0] fa;
    logic [31:0] da;
    mode = $urandom_range(0, 2);
    we   = 1'($urandom_range(0, 1));
    dw   = $urandom_range(0, 4);
    fw   = $urandom_range(0, 4);
    dtmo = ($urandom_range(0, 9) == 0);
    ftmo = ($urandom_range(0, 9) == 0);
    fa   = 32'($urandom_range(0, 255)) << 2;
    da   = 32'($urandom_range(0, 255)) << 2;
    fl   = -1;
    if ($urandom_range(0, 3) == 0) fl = $urandom_range(0, ftmo ? WL - 1 : fw);
    runTxn(mode, fa, da, we, $urandom, dw, fw, dtmo, ftmo, fl);
  endtask

  initial begin
    int lat;
    #3;
    check("rstMemReq", MemReq, 0);
    check("rstValids", {FetchValid, DataValid}, 2'b00);
    check("rstBusError", BusError, 0);
    check("rstMemAddr", MemAddr, 0);
    check("rstFetchData", FetchData, 0);
    check("rstDataRData", DataRData, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero-wait fetch
    memModel[32'h4] = 32'h0051_0113;
    runTxn(0, 32'h4, 32'h0, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0, -1);
    // Simultaneous data load and fetch, 2-wait memory
    runTxn(2, 32'h40, 32'h100, 1'b0, 32'h0, 2, 2, 1'b0, 1'b0, -1);
    // Store keeps DataRData
    runTxn(1, 32'h0, 32'h200, 1'b1, 32'hDEAD_BEEF, 2, 0, 1'b0, 1'b0, -1);
    // Flush while waiting, then the corrected fetch
    runTxn(0, 32'h80, 32'h0, 1'b0, 32'h0, 0, 3, 1'b0, 1'b0, 1);
    runTxn(0, 32'h200, 32'h0, 1'b0, 32'h0, 0, 1, 1'b0, 1'b0, -1);
    // Flush coinciding with MemReady
    runTxn(0, 32'h84, 32'h0, 1'b0, 32'h0, 0, 2, 1'b0, 1'b0, 2);
    // Fetch timeout with late MemReady
    runTxn(0, 32'h8, 32'h0, 1'b0, 32'h0, 0, 0, 1'b0, 1'b1, -1);

    for (int t = 0; t < 60; t++) randomTxn();

    // Asynchronous reset in the middle of a data access
    DataReq  = 1'b1;
    DataWe   = 1'b1;
    DataAddr = 32'h300;
    DataWData = 32'hA5A5_5A5A;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!MemReq && lat < 20);
    check("rstTestIssue", MemReq, 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("asyncRstMemReq", MemReq, 0);
    check("asyncRstMemWe", MemWe, 0);
    check("asyncRstMemAddr", MemAddr, 0);
    check("asyncRstMemWData", MemWData, 0);
    check("asyncRstValids", {FetchValid, DataValid}, 2'b00);
    check("asyncRstBusError", BusError, 0);
    check("asyncRstRData", {FetchData, DataRData}, 64'h0);
    DataReq = 1'b0;
    DataWe  = 1'b0;
    busErr    = 1'b0;
    lastRData = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("postRstMemReq", MemReq, 0);

    for (int t = 0; t < 5; t++) randomTxn();

    repeat (3) @(negedge clk);
    check("pendingPulses", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
